// File: rtl/rv32i_regfile_dbg.sv
// Debug initiator for the RV32I register file: halts the core, then
// dumps every GPR as a beat stream or writes a single GPR.
module rv32i_regfile_dbg #(
    parameter bit DUMP_X0 = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_op_i,
    input  logic [4:0]  cmd_addr_i,
    input  logic [31:0] cmd_data_i,
    output logic        halt_req_o,
    input  logic        halt_ack_i,
    output logic [4:0]  rf_rs1_o,
    output logic [4:0]  rf_rs2_o,
    output logic [4:0]  rf_rd_o,
    output logic        rf_we_o,
    output logic [31:0] rf_din_o,
    input  logic [31:0] rf_rsa_i,
    input  logic [31:0] rf_rsb_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [4:0]  out_addr_o,
    output logic [31:0] out_data_o,
    output logic        out_last_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        HALT_WAIT,
        READ,
        EMIT_A,
        EMIT_B,
        WRITE,
        RELEASE
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  addr_q, addr_d;
    logic        op_q, op_d;
    logic [31:0] data_q, data_d;
    logic [31:0] bufa_q, bufa_d;
    logic [31:0] bufb_q, bufb_d;
    logic [4:0]  idx_p1;

    assign idx_p1 = idx_q + 5'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            op_q    <= 1'b0;
            data_q  <= '0;
            bufa_q  <= '0;
            bufb_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            data_q  <= data_d;
            bufa_q  <= bufa_d;
            bufb_q  <= bufb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        op_d    = op_q;
        data_d  = data_q;
        bufa_d  = bufa_q;
        bufb_d  = bufb_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    op_d    = cmd_op_i;
                    addr_d  = cmd_addr_i;
                    data_d  = cmd_data_i;
                    idx_d   = DUMP_X0 ? 5'd0 : 5'd1;
                    state_d = HALT_WAIT;
                end
            end
            HALT_WAIT: begin
                if (halt_ack_i) state_d = op_q ? WRITE : READ;
            end
            READ: begin
                bufa_d  = rf_rsa_i;
                bufb_d  = rf_rsb_i;
                state_d = EMIT_A;
            end
            EMIT_A: begin
                if (out_ready_i) state_d = (idx_q == 5'd31) ? RELEASE : EMIT_B;
            end
            EMIT_B: begin
                if (out_ready_i) begin
                    if (idx_p1 == 5'd31) begin
                        state_d = RELEASE;
                    end else begin
                        idx_d   = idx_q + 5'd2;
                        state_d = READ;
                    end
                end
            end
            WRITE:   state_d = RELEASE;
            RELEASE: if (!halt_ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from state and registered fields only.
    always_comb begin
        cmd_ready_o = (state_q == IDLE);
        busy_o      = (state_q != IDLE);
        halt_req_o  = (state_q != IDLE) && (state_q != RELEASE);
        rf_rs1_o    = '0;
        rf_rs2_o    = '0;
        rf_rd_o     = '0;
        rf_din_o    = '0;
        rf_we_o     = 1'b0;
        out_valid_o = 1'b0;
        out_addr_o  = '0;
        out_data_o  = '0;
        out_last_o  = 1'b0;
        unique case (state_q)
            READ: begin
                rf_rs1_o = idx_q;
                rf_rs2_o = idx_p1;
            end
            EMIT_A: begin
                out_valid_o = 1'b1;
                out_addr_o  = idx_q;
                out_data_o  = bufa_q;
                out_last_o  = (idx_q == 5'd31);
            end
            EMIT_B: begin
                out_valid_o = 1'b1;
                out_addr_o  = idx_p1;
                out_data_o  = bufb_q;
                out_last_o  = (idx_p1 == 5'd31);
            end
            WRITE: begin
                rf_rd_o  = addr_q;
                rf_din_o = data_q;
                rf_we_o  = (addr_q != 5'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rv32i_regfile_dbg.sv
// Scoreboard bench: instance 0 has DUMP_X0=0, instance 1 has DUMP_X0=1;
// the instance under test is chosen by sel.
module tb_rv32i_regfile_dbg;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  cv;
    logic        cop;
    logic [4:0]  caddr;
    logic [31:0] cdata;
    logic [1:0]  ack;
    logic        out_ready;

    logic [1:0]  cmd_ready, hr, we, ov, ol, busy;
    logic [4:0]  rs1 [2];
    logic [4:0]  rs2 [2];
    logic [4:0]  rd [2];
    logic [4:0]  oa [2];
    logic [31:0] din [2];
    logic [31:0] od [2];
    logic [31:0] rsa [2];
    logic [31:0] rsb [2];

    logic [31:0] rf [2][32];
    logic [31:0] mem [2][32];
    logic        pre;

    int sel;
    int ack_dly;
    bit rnd;
    int checks = 0;
    int errors = 0;
    int span;

    logic [38:0] exp_q[$];
    logic [36:0] wq[$];

    for (genvar g = 0; g < 2; g++) begin : gi
        rv32i_regfile_dbg #(.DUMP_X0(1'(g))) u_dut (
            .clk_i(clk),
            .rst_i(rst),
            .cmd_valid_i(cv[g]),
            .cmd_ready_o(cmd_ready[g]),
            .cmd_op_i(cop),
            .cmd_addr_i(caddr),
            .cmd_data_i(cdata),
            .halt_req_o(hr[g]),
            .halt_ack_i(ack[g]),
            .rf_rs1_o(rs1[g]),
            .rf_rs2_o(rs2[g]),
            .rf_rd_o(rd[g]),
            .rf_we_o(we[g]),
            .rf_din_o(din[g]),
            .rf_rsa_i(rsa[g]),
            .rf_rsb_i(rsb[g]),
            .out_valid_o(ov[g]),
            .out_ready_i(out_ready),
            .out_addr_o(oa[g]),
            .out_data_o(od[g]),
            .out_last_o(ol[g]),
            .busy_o(busy[g])
        );
        assign rsa[g] = rf[g][rs1[g]];
        assign rsb[g] = rf[g][rs2[g]];
    end

    // Register file seen by the block
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (pre) begin
                for (int n = 0; n < 32; n++)
                    rf[g][n] <= (n == 0) ? 32'h0 : 32'h1000_0000 + n;
            end else if (we[g]) begin
                rf[g][rd[g]] <= din[g];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Core control path: acks halt ack_dly cycles after request
    initial begin
        int cnt [2];
        cnt[0] = 0;
        cnt[1] = 0;
        ack = 2'b00;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (!hr[g]) begin
                    ack[g] = 1'b0;
                    cnt[g] = 0;
                end else if (!ack[g]) begin
                    cnt[g]++;
                    if (cnt[g] >= ack_dly) ack[g] = 1'b1;
                end
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops expected beats / writes and checks the stream
    initial begin
        int cyc = 0;
        int cyc_first = 0;
        bit hold = 0;
        bit rel_chk = 0;
        logic [38:0] held;
        logic [38:0] e;
        logic [36:0] w;
        int g;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            g = sel;
            if (rst) begin
                hold = 0;
                rel_chk = 0;
                continue;
            end
            if (rel_chk) begin
                chk("halt_release", 64'(hr[g]), 64'd0);
                rel_chk = 0;
            end
            if (hold)
                chk("stall_stable", {25'd0, ov[g], oa[g], od[g], ol[g]},
                    {25'd0, held});
            if (ov[g] || we[g])
                chk("ack_held", 64'(ack[g]), 64'd1);
            if (ov[g] && out_ready) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL extra_beat: got addr %0d none expected",
                             oa[g]);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {26'd0, oa[g], od[g], ol[g]},
                        {26'd0, e[37:0]});
                    if (e[38]) cyc_first = cyc;
                    if (e[0]) begin
                        span = cyc - cyc_first;
                        rel_chk = 1;
                    end
                end
            end
            hold = ov[g] && !out_ready;
            held = {ov[g], oa[g], od[g], ol[g]};
            if (we[g]) begin
                if (wq.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL extra_write: got rd %0d none expected",
                             rd[g]);
                end else begin
                    w = wq.pop_front();
                    chk("write", {27'd0, rd[g], din[g]}, {27'd0, w});
                end
            end
        end
    end

    task automatic issue(input logic op, input logic [4:0] a,
                         input logic [31:0] d);
        int n = 0;
        int start;
        @(negedge clk);
        cop = op;
        caddr = a;
        cdata = d;
        cv = (sel == 1) ? 2'b10 : 2'b01;
        while (!cmd_ready[sel] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready", 64'(cmd_ready[sel]), 64'd1);
        if (op == 1'b0) begin
            start = (sel == 1) ? 0 : 1;
            for (int i = start; i < 32; i++)
                exp_q.push_back({i == start, 5'(i), mem[sel][i], i == 31});
        end else if (a != 5'd0) begin
            mem[sel][a] = d;
            wq.push_back({a, d});
        end
        @(posedge clk);
        @(negedge clk);
        cv = 2'b00;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((busy[sel] || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_in_time", 64'(n < 3000), 64'd1);
        @(negedge clk);
        #2;
        chk("idle", {62'd0, busy[sel], cmd_ready[sel]}, 64'd1);
        chk("writes_drained", 64'(wq.size()), 64'd0);
    endtask

    task automatic chk_reset(input int g);
        chk("rst_ctrl", {38'd0, cmd_ready[g], busy[g], hr[g], ov[g], ol[g],
            we[g], oa[g], rs1[g], rs2[g], rd[g]}, {38'd0, 6'b100000, 20'd0});
        chk("rst_data", {od[g], din[g]}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        pre = 1'b1;
        sel = 0;
        ack_dly = 2;
        rnd = 0;
        cv = 2'b00;
        cop = 1'b0;
        caddr = '0;
        cdata = '0;
        span = 0;
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 32; i++)
                mem[g][i] = (i == 0) ? 32'h0 : 32'h1000_0000 + i;
        repeat (3) @(negedge clk);
        pre = 1'b0;
        #2;
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;

        // x1..x31 dump, ready high
        sel = 0;
        issue(1'b0, 5'd0, 32'd0);
        wait_done();
        chk("dump_span", 64'(span), 64'd45);

        // x0..x31 dump under random backpressure
        sel = 1;
        rnd = 1;
        issue(1'b0, 5'd0, 32'd0);
        wait_done();
        rnd = 0;

        // single write then dump
        issue(1'b1, 5'd5, 32'hDEAD_BEEF);
        wait_done();
        issue(1'b0, 5'd0, 32'd0);
        wait_done();

        // write to x0 is a no-op
        issue(1'b1, 5'd0, 32'hFFFF_FFFF);
        wait_done();

        // slow halt ack
        ack_dly = 21;
        issue(1'b1, 5'd9, $urandom);
        for (int i = 0; i < 20; i++) begin
            #2;
            chk("halt_wait", {45'd0, hr[sel], busy[sel], we[sel], ov[sel],
                rs1[sel], rs2[sel], rd[sel]}, {45'd0, 4'b1100, 15'd0});
            @(negedge clk);
        end
        ack_dly = 2;
        wait_done();

        // random writes then dump, both instances
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int k = 0; k < 6; k++) begin
                issue(1'b1, 5'($urandom_range(0, 31)), $urandom);
                wait_done();
            end
            rnd = 1;
            issue(1'b0, 5'd0, 32'd0);
            wait_done();
            rnd = 0;
        end

        // reset in the middle of a dump
        sel = 0;
        issue(1'b0, 5'd0, 32'd0);
        n = 0;
        while (!(ov[0] && oa[0] == 5'd10) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reach_beat10", 64'(n < 500), 64'd1);
        rst = 1'b1;
        #1;
        chk_reset(0);
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        wq.delete();
        rst = 1'b0;
        issue(1'b0, 5'd0, 32'd0);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
